// File: rtl/xfill_pattern_driver.sv
// rtl/xfill_pattern_driver.sv - applies don't-care-filled test vectors to an ALU and strobes its response
module xfill_pattern_driver #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_value,
    input  logic [4:0]  in_care,
    input  logic [1:0]  in_xpct,
    input  logic [1:0]  in_mask,
    input  logic [1:0]  fill_mode,
    output logic [1:0]  ain,
    output logic [1:0]  bin,
    output logic        sel,
    input  logic [1:0]  zout,
    output logic        pat_done,
    output logic        pat_fail,
    output logic [15:0] pat_count,
    output logic [15:0] fail_count,
    output logic [15:0] toggle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        STROBE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  settle_q;
    logic [4:0]  vec_q;
    logic [1:0]  xpct_q;
    logic [1:0]  mask_q;
    logic        done_q;
    logic        fail_q;
    logic [15:0] pat_count_q;
    logic [15:0] fail_count_q;
    logic [15:0] toggle_q;

    logic [4:0]  fill_d;
    logic [4:0]  diff_d;
    logic [2:0]  pop_d;
    logic [16:0] toggle_sum_d;
    logic [15:0] toggle_d;
    logic        miscompare_d;
    logic        accept_d;

    // Don't-care fill: adjacent-fill reuses the bit currently on the ALU inputs
    always_comb begin
        fill_d = '0;
        for (int i = 0; i < 5; i++) begin
            if (in_care[i]) begin
                fill_d[i] = in_value[i];
            end else begin
                case (fill_mode)
                    2'b01:   fill_d[i] = 1'b1;
                    2'b10:   fill_d[i] = vec_q[i];
                    default: fill_d[i] = 1'b0;
                endcase
            end
        end
    end

    // Transition count of the new vector against the one still applied, saturating
    always_comb begin
        diff_d = fill_d ^ vec_q;
        pop_d  = '0;
        for (int i = 0; i < 5; i++) begin
            pop_d = pop_d + {2'b00, diff_d[i]};
        end
        toggle_sum_d = {1'b0, toggle_q} + {14'd0, pop_d};
        toggle_d     = toggle_sum_d[16] ? 16'hFFFF : toggle_sum_d[15:0];
    end

    // Masked response compare; an unknown level on a compared bit is a miscompare
    always_comb begin
        miscompare_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (mask_q[i] && (zout[i] !== xpct_q[i])) begin
                miscompare_d = 1'b1;
            end
        end
    end

    assign accept_d = in_valid && (state_q == IDLE);

    // Pattern sequencer: accept, hold for SETTLE cycles, strobe, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            vec_q        <= '0;
            xpct_q       <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            pat_count_q  <= '0;
            fail_count_q <= '0;
            toggle_q     <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        vec_q    <= fill_d;
                        xpct_q   <= in_xpct;
                        mask_q   <= in_mask;
                        toggle_q <= toggle_d;
                        settle_q <= '0;
                        state_q  <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= STROBE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                STROBE: begin
                    done_q  <= 1'b1;
                    fail_q  <= miscompare_d;
                    state_q <= IDLE;
                    if (pat_count_q != 16'hFFFF) begin
                        pat_count_q <= pat_count_q + 16'd1;
                    end
                    if (miscompare_d && (fail_count_q != 16'hFFFF)) begin
                        fail_count_q <= fail_count_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign ain          = vec_q[4:3];
    assign bin          = vec_q[2:1];
    assign sel          = vec_q[0];
    assign pat_done     = done_q;
    assign pat_fail     = fail_q;
    assign pat_count    = pat_count_q;
    assign fail_count   = fail_count_q;
    assign toggle_count = toggle_q;

endmodule

// File: tb/tb_xfill_pattern_driver.sv
// tb/tb_xfill_pattern_driver.sv - directed self-checking bench for xfill_pattern_driver
module tb_xfill_pattern_driver;

    localparam int SETTLE = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_value;
    logic [4:0]  in_care;
    logic [1:0]  in_xpct;
    logic [1:0]  in_mask;
    logic [1:0]  fill_mode;
    logic [1:0]  ain;
    logic [1:0]  bin;
    logic        sel;
    logic [1:0]  zout;
    logic        pat_done;
    logic        pat_fail;
    logic [15:0] pat_count;
    logic [15:0] fail_count;
    logic [15:0] toggle_count;

    int errors;
    int checks;

    xfill_pattern_driver #(.SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .in_care      (in_care),
        .in_xpct      (in_xpct),
        .in_mask      (in_mask),
        .fill_mode    (fill_mode),
        .ain          (ain),
        .bin          (bin),
        .sel          (sel),
        .zout         (zout),
        .pat_done     (pat_done),
        .pat_fail     (pat_fail),
        .pat_count    (pat_count),
        .fail_count   (fail_count),
        .toggle_count (toggle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one pattern from IDLE and waits for its pat_done; lat = edges after the accept edge
    task automatic apply_pattern(input logic [4:0] value, input logic [4:0] care,
                                 input logic [1:0] xpct, input logic [1:0] mask,
                                 input logic [1:0] mode, output logic [4:0] vec,
                                 output int lat, output logic fail);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        in_valid  = 1'b1;
        in_value  = value;
        in_care   = care;
        in_xpct   = xpct;
        in_mask   = mask;
        fill_mode = mode;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vec  = {ain, bin, sel};
        lat  = -1;
        fail = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (pat_done) begin
                lat  = c;
                fail = pat_fail;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_value = 5'b11111;
        in_care  = 5'b11111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++;
        if ({ain, bin, sel} !== 5'b00000) begin errors++; $display("FAIL reset_vec got=%b exp=00000", {ain, bin, sel}); end
        checks++;
        if ({pat_done, pat_fail} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {pat_done, pat_fail}); end
        checks++;
        if ({pat_count, fail_count, toggle_count} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", pat_count, fail_count, toggle_count);
        end
        for (int c = 0; c < SETTLE + 3; c++) begin
            @(negedge clk);
            checks++;
            if (pat_done !== 1'b0) begin errors++; $display("FAIL reset_dropped_pattern cycle=%0d pat_done=%b exp=0", c, pat_done); end
        end
    endtask

    task automatic test_zero_fill();
        logic [4:0] vec;
        int lat;
        logic f;
        zout = 2'b10;
        apply_pattern(5'b11101, 5'b11111, 2'b10, 2'b11, 2'b00, vec, lat, f);
        checks++;
        if ({ain, bin, sel} !== {2'b11, 2'b10, 1'b1}) begin errors++; $display("FAIL zero_fill_vec got=%b exp=11101", {ain, bin, sel}); end
        checks++;
        if (lat !== SETTLE + 1) begin errors++; $display("FAIL zero_fill_latency got=%0d exp=%0d", lat, SETTLE + 1); end
        checks++;
        if (f !== 1'b0) begin errors++; $display("FAIL zero_fill_fail got=%b exp=0", f); end
        checks++;
        if (pat_count !== 16'd1) begin errors++; $display("FAIL zero_fill_pat_count got=%0d exp=1", pat_count); end
        checks++;
        if (toggle_count !== 16'd4) begin errors++; $display("FAIL zero_fill_toggles got=%0d exp=4", toggle_count); end
        @(negedge clk);
        checks++;
        if (pat_done !== 1'b0) begin errors++; $display("FAIL done_single_cycle got=%b exp=0", pat_done); end
        checks++;
        if ({ain, bin, sel} !== 5'b11101) begin errors++; $display("FAIL vec_hold got=%b exp=11101", {ain, bin, sel}); end
    endtask

    task automatic test_adjacent_fill();
        logic [4:0] vec;
        int lat;
        logic f;
        zout = 2'b11;
        apply_pattern(5'b00011, 5'b00011, 2'b11, 2'b11, 2'b10, vec, lat, f);
        checks++;
        if (vec !== 5'b11111) begin errors++; $display("FAIL adjacent_vec got=%b exp=11111", vec); end
        checks++;
        if (toggle_count !== 16'd5) begin errors++; $display("FAIL adjacent_toggles got=%0d exp=5", toggle_count); end
        checks++;
        if (pat_count !== 16'd2 || f !== 1'b0) begin errors++; $display("FAIL adjacent_done got=%0d/%b exp=2/0", pat_count, f); end
    endtask

    task automatic test_one_zero_fill();
        logic [4:0] vec;
        int lat;
        logic f;
        apply_pattern(5'b00000, 5'b00000, 2'b00, 2'b00, 2'b01, vec, lat, f);
        checks++;
        if (vec !== 5'b11111) begin errors++; $display("FAIL one_fill_vec got=%b exp=11111", vec); end
        apply_pattern(5'b11111, 5'b00000, 2'b00, 2'b00, 2'b00, vec, lat, f);
        checks++;
        if (vec !== 5'b00000) begin errors++; $display("FAIL zero_fill_dc_vec got=%b exp=00000", vec); end
        checks++;
        if (toggle_count !== 16'd10) begin errors++; $display("FAIL zero_fill_dc_toggles got=%0d exp=10", toggle_count); end
        apply_pattern(5'b11111, 5'b10101, 2'b00, 2'b00, 2'b11, vec, lat, f);
        checks++;
        if (vec !== 5'b10101) begin errors++; $display("FAIL mode11_vec got=%b exp=10101", vec); end
        checks++;
        if (toggle_count !== 16'd13 || pat_count !== 16'd5) begin
            errors++;
            $display("FAIL mode11_counts got=%0d/%0d exp=13/5", toggle_count, pat_count);
        end
    endtask

    task automatic test_fail();
        logic [4:0] vec;
        int lat;
        logic f;
        zout = 2'b01;
        apply_pattern(5'b00000, 5'b11111, 2'b00, 2'b11, 2'b00, vec, lat, f);
        checks++;
        if (f !== 1'b1) begin errors++; $display("FAIL miscompare_pulse got=%b exp=1", f); end
        checks++;
        if (fail_count !== 16'd1) begin errors++; $display("FAIL miscompare_count got=%0d exp=1", fail_count); end
        @(negedge clk);
        checks++;
        if (pat_fail !== 1'b0) begin errors++; $display("FAIL fail_single_cycle got=%b exp=0", pat_fail); end
        apply_pattern(5'b00000, 5'b11111, 2'b00, 2'b00, 2'b00, vec, lat, f);
        checks++;
        if (f !== 1'b0 || fail_count !== 16'd1) begin errors++; $display("FAIL mask00 got=%b/%0d exp=0/1", f, fail_count); end
        apply_pattern(5'b00000, 5'b11111, 2'b00, 2'b10, 2'b00, vec, lat, f);
        checks++;
        if (f !== 1'b0 || fail_count !== 16'd1) begin errors++; $display("FAIL mask10 got=%b/%0d exp=0/1", f, fail_count); end
        checks++;
        if (pat_count !== 16'd8) begin errors++; $display("FAIL fail_pat_count got=%0d exp=8", pat_count); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int done;
        int last;
        int bad;
        int stalls;
        logic [15:0] base;
        acc    = 0;
        done   = 0;
        last   = -1;
        bad    = 0;
        stalls = 0;
        @(negedge clk);
        base      = pat_count;
        zout      = 2'b00;
        in_value  = 5'b01010;
        in_care   = 5'b11111;
        in_xpct   = 2'b00;
        in_mask   = 2'b00;
        fill_mode = 2'b00;
        in_valid  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (pat_done) done++;
            if (acc == 3) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (last >= 0 && (c - last) != SETTLE + 2) bad++;
                last = c;
                acc++;
                in_value = in_value + 5'd3;
            end else if (in_valid && !in_ready) begin
                stalls++;
            end
            if (done == 3) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc !== 3 || done !== 3) begin errors++; $display("FAIL b2b_counts accepts=%0d dones=%0d exp=3/3", acc, done); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_period bad_intervals=%0d exp=0", bad); end
        checks++;
        if (stalls !== 2 * (SETTLE + 1)) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=%0d", stalls, 2 * (SETTLE + 1)); end
        checks++;
        if (pat_count !== base + 16'd3) begin errors++; $display("FAIL b2b_pat_count got=%0d exp=%0d", pat_count, base + 16'd3); end
    endtask

    task automatic test_reset_mid_apply();
        logic [4:0] vec;
        int lat;
        logic f;
        @(negedge clk);
        in_valid  = 1'b1;
        in_value  = 5'b11111;
        in_care   = 5'b11111;
        in_mask   = 2'b11;
        fill_mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ain, bin, sel} !== 5'b00000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_vec got=%b ready=%b exp=00000/1", {ain, bin, sel}, in_ready);
        end
        checks++;
        if ({pat_count, fail_count, toggle_count} !== 48'd0) begin
            errors++;
            $display("FAIL midreset_counters got=%0d/%0d/%0d exp=0/0/0", pat_count, fail_count, toggle_count);
        end
        for (int c = 0; c < SETTLE + 3; c++) begin
            checks++;
            if (pat_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done cycle=%0d got=%b exp=0", c, pat_done); end
            @(negedge clk);
        end
        zout = 2'b10;
        apply_pattern(5'b00110, 5'b11111, 2'b10, 2'b11, 2'b00, vec, lat, f);
        checks++;
        if (lat !== SETTLE + 1 || f !== 1'b0) begin errors++; $display("FAIL midreset_fresh got=%0d/%b exp=%0d/0", lat, f, SETTLE + 1); end
        checks++;
        if (pat_count !== 16'd1 || toggle_count !== 16'd2) begin
            errors++;
            $display("FAIL midreset_fresh_counts got=%0d/%0d exp=1/2", pat_count, toggle_count);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_care   = '0;
        in_xpct   = '0;
        in_mask   = '0;
        fill_mode = '0;
        zout      = '0;
        test_reset();
        test_zero_fill();
        test_adjacent_fill();
        test_one_zero_fill();
        test_fail();
        test_back_to_back();
        test_reset_mid_apply();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xfill_pattern_driver.md
XFILL_PATTERN_DRIVER -- requirements
Module: xfill_pattern_driver

Interface
REQ-001 Parameter SETTLE, default 2, meaning: number of cycles the applied vector is held before the response strobe; legal range 1..15.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port in_valid  input  1  pattern available on in_* inputs.
REQ-005 Port in_ready  output  1  block can accept a pattern this cycle.
REQ-006 Port in_value  input  5  care-bit values; [4:3]=ain, [2:1]=bin, [0]=sel.
REQ-007 Port in_care  input  5  per-bit care mask; 1=specified, 0=don't-care to be filled.
REQ-008 Port in_xpct  input  2  expected zout[1:0].
REQ-009 Port in_mask  input  2  per-bit compare enable for zout[1:0].
REQ-010 Port fill_mode  input  2  00 zero-fill, 01 one-fill, 10 adjacent-fill, 11 treated as zero-fill.
REQ-011 Port ain  output  2  drives alu ain.
REQ-012 Port bin  output  2  drives alu bin.
REQ-013 Port sel  output  1  drives alu sel.
REQ-014 Port zout  input  2  response from alu, combinational from ain/bin/sel.
REQ-015 Port pat_done  output  1  one-cycle pulse, pattern strobed.
REQ-016 Port pat_fail  output  1  one-cycle pulse coincident with pat_done on miscompare.
REQ-017 Port pat_count  output  16  patterns completed, saturating.
REQ-018 Port fail_count  output  16  failing patterns, saturating.
REQ-019 Port toggle_count  output  16  total applied-PI bit transitions, saturating.

Function
REQ-020 FSM states IDLE, APPLY, STROBE; in_ready=1 only in IDLE.
REQ-021 Handshake: pattern accepted at rising edge where in_valid&in_ready=1; in_* ignored otherwise.
REQ-022 Fill per bit i: care=1 -> in_value[i]; care=0 -> 0 (zero/11), 1 (one), previous applied bit i (adjacent).
REQ-023 At accept edge: filled vector loaded into {ain,bin,sel}, in_xpct/in_mask latched, state->APPLY, settle counter cleared.
REQ-024 toggle_count adds popcount(new vector XOR previous applied vector) at accept edge, saturating at 16'hFFFF.
REQ-025 APPLY lasts exactly SETTLE cycles, then STROBE for one cycle.
REQ-026 At the edge ending STROBE: fail = OR over i of mask[i] & (zout[i] !== xpct[i]); X/Z on a masked bit counts as mismatch.
REQ-027 pat_done=1 and pat_fail=fail during the single cycle after that edge; state->IDLE at that edge, in_ready=1 in the same cycle.
REQ-028 pat_count increments (and fail_count if fail) at the same edge, each saturating at 16'hFFFF.
REQ-029 Pattern period from accept to next possible accept = SETTLE+2 cycles.
REQ-030 {ain,bin,sel} hold the last applied vector until the next accept; no return-to-zero.
REQ-031 in_valid held during APPLY/STROBE is not consumed; pattern stays pending until IDLE.
REQ-032 Mask 2'b00: pat_fail=0 regardless of zout.

Reset
REQ-033 rst=1 at an edge: state->IDLE; ain, bin, sel, pat_done, pat_fail, all counters, previous-vector register = 0; in_ready=1 in the cycle after.
REQ-034 Reset in APPLY or STROBE aborts the pattern: no pat_done, no counter update.
REQ-035 rst has priority over a simultaneous handshake; that pattern is dropped.

Verification
REQ-036 Reset; zero-fill, value 5'b11101, care 5'b11111, xpct 2'b10, mask 2'b11, alu zout=2'b10 -> ain=11, bin=10, sel=1; pat_done at accept+SETTLE+2; pat_fail=0; pat_count=1; toggle_count=4.
REQ-037 Then adjacent-fill, value 5'b00011, care 5'b00011 -> applied 5'b11111; toggle_count +1.
REQ-038 One-fill, care 5'b00000 -> applied 5'b11111; zero-fill same -> 5'b00000.
REQ-039 xpct 2'b00, mask 2'b11, zout 2'b01 -> pat_fail pulse, fail_count=1; repeat with mask 2'b00 -> no fail, fail_count stays 1.
REQ-040 in_valid held continuously -> in_ready low during APPLY/STROBE, back-to-back patterns every SETTLE+2 cycles, none lost or duplicated.
REQ-041 rst asserted mid-APPLY -> next cycle outputs and counters 0, no pat_done; fresh pattern afterwards completes normally.
